// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   fetch_state_e    : fetch unit FSM states (BOOT, REQ, WAIT, HOLD)
//   INSN_BYTES       : size of one instruction in bytes
//   DEFAULT_RESET_PC : default first fetch address after reset
//   alignWord()      : forces an address onto a word boundary
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are always word aligned, so the two low address bits carry
    // no information and are forced to zero wherever an address enters the PC.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch with redirect support. Issues one word-aligned
// request at a time to instruction memory, captures the returned word and
// presents it to decode together with its fall-through address (pc + 4).
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst_n           : asynchronous active-low reset
//   redirect_valid  : taken branch / jump from the PC stage
//   redirect_target : redirect address, low two bits ignored
//   imem_req_valid  : instruction memory request strobe
//   imem_req_addr   : request address (always word aligned)
//   imem_req_ready  : memory accepts the request
//   imem_rsp_valid  : memory returns instruction data
//   imem_rsp_data   : returned instruction word
//   inst_valid      : fetched instruction available to decode
//   inst_data       : fetched instruction word
//   inst_npc        : address of the fetched instruction + 4
//   inst_ready      : decode accepts the instruction
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_npc,
    input  logic        inst_ready
);

    localparam logic [31:0] BOOT_PC = alignWord(RESET_PC);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         drop_q;
    logic         reqValid_q;
    logic         instValid_q;
    logic [31:0]  instData_q;
    logic [31:0]  instNpc_q;

    logic [31:0]  pcInc;
    logic [31:0]  redirectPc;

    // Sequential fall-through address; plain 32-bit addition wraps naturally.
    assign pcInc      = pc_q + 32'(INSN_BYTES);
    assign redirectPc = alignWord(redirect_target);

    // Fetch FSM. A redirect always overwrites the PC on the edge it is seen,
    // regardless of state. drop_q remembers that the single request currently
    // in flight belongs to a stale path, so its response must be thrown away.
    // reqValid_q is set on every transition into REQ so the request strobe
    // comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_BOOT;
            pc_q        <= BOOT_PC;
            drop_q      <= 1'b0;
            reqValid_q  <= 1'b0;
            instValid_q <= 1'b0;
            instData_q  <= 32'h0;
            instNpc_q   <= 32'h0;
        end else begin
            case (state_q)
                FETCH_BOOT: begin
                    state_q    <= FETCH_REQ;
                    reqValid_q <= 1'b1;
                    if (redirect_valid) begin
                        pc_q <= redirectPc;
                    end
                end

                FETCH_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirectPc;
                    end
                    // A request accepted on the same edge as a redirect was
                    // issued for the old path; its response is dropped later.
                    if (imem_req_ready) begin
                        state_q    <= FETCH_WAIT;
                        reqValid_q <= 1'b0;
                        drop_q     <= redirect_valid;
                    end
                end

                FETCH_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirectPc;
                        if (imem_rsp_valid) begin
                            // Response for the abandoned path is retired now.
                            state_q    <= FETCH_REQ;
                            reqValid_q <= 1'b1;
                            drop_q     <= 1'b0;
                        end else begin
                            drop_q     <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop_q) begin
                            state_q    <= FETCH_REQ;
                            reqValid_q <= 1'b1;
                            drop_q     <= 1'b0;
                        end else begin
                            state_q     <= FETCH_HOLD;
                            instValid_q <= 1'b1;
                            instData_q  <= imem_rsp_data;
                            instNpc_q   <= pcInc;
                            pc_q        <= pcInc;
                        end
                    end
                end

                FETCH_HOLD: begin
                    // PC already points past the held instruction, so leaving
                    // HOLD needs no PC update unless a redirect arrives.
                    if (redirect_valid || inst_ready) begin
                        state_q     <= FETCH_REQ;
                        reqValid_q  <= 1'b1;
                        instValid_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_q <= redirectPc;
                        end
                    end
                end

                default: begin
                    state_q     <= FETCH_BOOT;
                    reqValid_q  <= 1'b0;
                    instValid_q <= 1'b0;
                    drop_q      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = reqValid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = instValid_q;
    assign inst_data      = instData_q;
    assign inst_npc       = instNpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives two fetch units in lockstep (reset PC 0 and reset PC 0xFFFF_FFFC)
// against a single-outstanding memory model and a transaction-level
// reference model of the expected instruction stream.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] PC_A = 32'h0000_0000;
   localparam logic [31:0] PC_B = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        inst_ready = 1'b0;

   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_npc;

   logic        imemReqValidB;
   logic [31:0] imemReqAddrB;
   logic        instValidB;
   logic [31:0] instDataB;
   logic [31:0] instNpcB;

   // Expected-stream model state
   logic [31:0] expPc;
   logic [31:0] pendAddr;
   logic [31:0] holdData;
   logic [31:0] holdNpc;
   bit          pending;
   bit          stale;
   bit          holding;
   bit          boot;

   logic [31:0] reqLog[$];
   logic [31:0] npcLog[$];
   logic [31:0] reqLogB[$];
   logic [31:0] npcLogB[$];

   // Stimulus knobs (percent probabilities and one-shot forces)
   int          readyPct;
   int          rspPct;
   int          instReadyPct;
   int          redirPct;
   int          spurPct;
   bit          forceRedir;
   logic [31:0] forceTarget;
   bit          forceSpur;

   int          total = 0;
   int          bad = 0;

   fetch_unit #(.RESET_PC(PC_A)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_npc        (inst_npc),
      .inst_ready      (inst_ready)
   );

   fetch_unit #(.RESET_PC(PC_B)) u_dutWrap (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imemReqValidB),
      .imem_req_addr   (imemReqAddrB),
      .imem_req_ready  (imem_req_ready),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (instValidB),
      .inst_data       (instDataB),
      .inst_npc        (instNpcB),
      .inst_ready      (inst_ready)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Memory contents: a scrambled function of the address, so a word fetched
   // from the wrong address is visible in inst_data.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic bit roll(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   // Single comparison point: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left at a falling edge. Drives memory,
   // decode and redirect inputs, checks the outputs against the model, then
   // advances the model by what happened on the rising edge.
   task automatic applyStimulus();
      bit          reqFire;
      bit          reqFireB;
      bit          rspFire;
      bit          hs;
      bit          redir;
      bit          deliver;
      logic [31:0] reqAddr;
      logic [31:0] reqAddrB;
      logic [31:0] tgt;
      bit          expReq;

      imem_req_ready = roll(readyPct);
      if (pending) begin
         imem_rsp_valid = roll(rspPct);
         imem_rsp_data  = memWord(pendAddr);
      end else begin
         imem_rsp_valid = forceSpur || roll(spurPct);
         imem_rsp_data  = $urandom;
      end
      inst_ready      = roll(instReadyPct);
      redirect_valid  = forceRedir || roll(redirPct);
      redirect_target = forceRedir ? forceTarget : $urandom;
      #1;

      expReq = !holding && !pending && !boot;
      checkOutput("inst_valid", 32'(inst_valid), 32'(holding));
      if (holding) begin
         checkOutput("inst_data", inst_data, holdData);
         checkOutput("inst_npc", inst_npc, holdNpc);
      end
      checkOutput("imem_req_valid", 32'(imem_req_valid), 32'(expReq));
      checkOutput("imem_req_valid_wrap", 32'(imemReqValidB), 32'(expReq));
      if (expReq) begin
         checkOutput("imem_req_addr", imem_req_addr, expPc);
      end

      reqFire  = imem_req_valid && imem_req_ready;
      reqFireB = imemReqValidB && imem_req_ready;
      reqAddr  = imem_req_addr;
      reqAddrB = imemReqAddrB;
      rspFire  = pending && imem_rsp_valid;
      hs       = inst_valid && inst_ready;
      redir    = redirect_valid;
      tgt      = {redirect_target[31:2], 2'b00};

      @(posedge clk);
      boot    = 1'b0;
      deliver = 1'b0;
      if (rspFire) begin
         deliver = !stale && !redir;
         pending = 1'b0;
         stale   = 1'b0;
      end
      if (reqFire) begin
         pending  = 1'b1;
         pendAddr = reqAddr;
         stale    = redir;
         reqLog.push_back(reqAddr);
      end else if (pending && redir) begin
         stale = 1'b1;
      end
      if (reqFireB) begin
         reqLogB.push_back(reqAddrB);
      end
      if (deliver) begin
         holdData = memWord(expPc);
         holdNpc  = expPc + 32'd4;
         expPc    = expPc + 32'd4;
         holding  = 1'b1;
         npcLog.push_back(holdNpc);
      end else if (holding && (hs || redir)) begin
         holding = 1'b0;
      end
      if (redir) begin
         expPc = tgt;
      end

      @(negedge clk);
      if (deliver) begin
         npcLogB.push_back(instNpcB);
      end
      forceRedir = 1'b0;
      forceSpur  = 1'b0;
   endtask

   // Asynchronous reset pulse starting between edges; outputs must clear
   // before any clock edge arrives. Entered and left at a falling edge.
   task automatic applyReset();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      inst_ready     = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
      checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
      checkOutput("rst_inst_data", inst_data, 32'h0);
      checkOutput("rst_inst_npc", inst_npc, 32'h0);
      checkOutput("rst_req_addr", imem_req_addr, PC_A);
      checkOutput("rst_req_addr_wrap", imemReqAddrB, PC_B);
      checkOutput("rst_inst_valid_wrap", 32'(instValidB), 32'h0);
      expPc   = PC_A;
      pending = 1'b0;
      stale   = 1'b0;
      holding = 1'b0;
      boot    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit          ok;
      int          n0;
      logic [31:0] savedData;
      logic [31:0] savedNpc;

      forceRedir = 1'b0;
      forceSpur  = 1'b0;
      forceTarget = 32'h0;
      readyPct = 100; rspPct = 100; instReadyPct = 100; redirPct = 0; spurPct = 0;

      @(negedge clk);
      applyReset();

      // Zero-latency memory, decode always ready: 4 instructions in 12 cycles
      for (int i = 0; i < 12; i++) applyStimulus();
      checkOutput("seq_count", 32'(npcLog.size()), 32'd4);
      checkOutput("seq_req_count", 32'(reqLog.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("seq_req_addr", reqLog[i], 32'(i * 4));
         checkOutput("seq_npc", npcLog[i], 32'(i * 4 + 4));
      end
      checkOutput("wrap_npc_count", 32'(npcLogB.size() >= 1), 32'd1);
      checkOutput("wrap_first_npc", npcLogB[0], 32'h0000_0000);
      checkOutput("wrap_req_count", 32'(reqLogB.size() >= 2), 32'd1);
      checkOutput("wrap_first_req", reqLogB[0], PC_B);
      checkOutput("wrap_second_req", reqLogB[1], 32'h0000_0000);

      // Decode stalls for 5 cycles while an instruction is held
      instReadyPct = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (holding) begin ok = 1'b1; break; end
         applyStimulus();
      end
      checkOutput("stall_reach_hold", 32'(ok), 32'd1);
      savedData = holdData;
      savedNpc  = holdNpc;
      n0 = reqLog.size();
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("stall_data", inst_data, savedData);
      checkOutput("stall_npc", inst_npc, savedNpc);
      checkOutput("stall_no_req", 32'(reqLog.size()), 32'(n0));
      instReadyPct = 100;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (reqLog.size() > n0) begin ok = 1'b1; break; end
      end
      checkOutput("stall_resume", 32'(ok), 32'd1);
      checkOutput("stall_resume_addr", reqLog[$], savedNpc);

      // Redirect to an unaligned target while waiting for memory
      rspPct = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pending && !stale) begin ok = 1'b1; break; end
         applyStimulus();
      end
      checkOutput("wait_reach", 32'(ok), 32'd1);
      forceRedir  = 1'b1;
      forceTarget = 32'h0000_0103;
      applyStimulus();
      rspPct = 100;
      n0 = npcLog.size();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (npcLog.size() > n0) begin ok = 1'b1; break; end
      end
      checkOutput("wait_redir_done", 32'(ok), 32'd1);
      checkOutput("wait_redir_req", reqLog[$], 32'h0000_0100);
      checkOutput("wait_redir_npc", npcLog[$], 32'h0000_0104);

      // Redirect in HOLD on the same edge as the decode handshake
      instReadyPct = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (holding) begin ok = 1'b1; break; end
         applyStimulus();
      end
      checkOutput("hold_reach", 32'(ok), 32'd1);
      instReadyPct = 100;
      forceRedir   = 1'b1;
      forceTarget  = 32'h0000_2000;
      n0 = reqLog.size();
      applyStimulus();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (reqLog.size() > n0) begin ok = 1'b1; break; end
      end
      checkOutput("hold_redir_req_seen", 32'(ok), 32'd1);
      checkOutput("hold_redir_req", reqLog[$], 32'h0000_2000);
      n0 = npcLog.size();
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("hold_redir_npc_count", 32'(npcLog.size() > n0), 32'd1);
      checkOutput("hold_redir_npc", npcLog[n0], 32'h0000_2004);

      // Randomized traffic: stalls, latency, spurious responses, redirects
      readyPct = 70; rspPct = 60; instReadyPct = 60; redirPct = 8; spurPct = 20;
      for (int i = 0; i < 600; i++) applyStimulus();
      $display("[TB] random phase delivered %0d instructions", npcLog.size());

      // Reset while a request is outstanding, then a late response
      readyPct = 100; rspPct = 0; instReadyPct = 100; redirPct = 0; spurPct = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pending) begin ok = 1'b1; break; end
         applyStimulus();
      end
      checkOutput("rst_wait_reach", 32'(ok), 32'd1);
      applyReset();
      reqLog.delete();
      npcLog.delete();
      rspPct = 100;
      forceSpur = 1'b1;
      applyStimulus();
      forceSpur = 1'b1;
      applyStimulus();
      for (int i = 0; i < 8; i++) applyStimulus();
      checkOutput("rst_restart_count", 32'(reqLog.size() >= 1), 32'd1);
      checkOutput("rst_restart_addr", reqLog[0], PC_A);
      checkOutput("rst_restart_npc_count", 32'(npcLog.size() >= 1), 32'd1);
      checkOutput("rst_restart_npc", npcLog[0], 32'h0000_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-004 Port redirect_valid, input, 1, is a taken branch or jump from the PC stage.
REQ-005 Port redirect_target, input, 32, is the redirect address; bits [1:0] ignored and treated as 2'b00.
REQ-006 Port imem_req_valid, output, 1, is the instruction-memory request strobe.
REQ-007 Port imem_req_addr, output, 32, is the request address, always word-aligned.
REQ-008 Port imem_req_ready, input, 1, is memory acceptance of the request.
REQ-009 Port imem_rsp_valid, input, 1, marks valid instruction data from memory.
REQ-010 Port imem_rsp_data, input, 32, is the instruction word.
REQ-011 Port inst_valid, output, 1, marks a fetched instruction presented to decode/PC stage.
REQ-012 Port inst_data, output, 32, is the fetched instruction.
REQ-013 Port inst_npc, output, 32, is the fetched instruction's address + 4 (feeds PC-stage npc).
REQ-014 Port inst_ready, input, 1, is downstream acceptance; handshake = inst_valid & inst_ready.

Function
REQ-015 FSM states SHALL be BOOT, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-016 BOOT SHALL go to REQ on the first edge after rst_n deasserts; no request in BOOT.
REQ-017 In REQ, imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready go to WAIT, else stay REQ with addr held stable.
REQ-018 In WAIT, imem_rsp_valid SHALL capture imem_rsp_data into inst_data, set inst_npc=pc+4, pc<=pc+4, inst_valid<=1, go HOLD.
REQ-019 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-020 In HOLD, inst_valid, inst_data, inst_npc SHALL hold until handshake; on handshake inst_valid<=0, go REQ.
REQ-021 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-latency memory and inst_ready=1.
REQ-022 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 Redirect SHALL have priority over sequential advance: pc<={redirect_target[31:2],2'b00} on that edge in every state.
REQ-024 Redirect in BOOT or REQ without request handshake: go/stay REQ; next request uses target.
REQ-025 Redirect in REQ coinciding with request handshake: go WAIT with drop flag set.
REQ-026 Redirect in WAIT without response: set drop flag, stay WAIT; redirect with response same cycle: discard response, go REQ, drop clear.
REQ-027 Response in WAIT with drop flag set SHALL be discarded (no inst_valid, pc unchanged), drop cleared, go REQ.
REQ-028 Redirect in HOLD SHALL clear inst_valid and go REQ; a handshake in the same cycle still counts as consumed.
REQ-029 Multiple back-to-back redirects: last one wins; drop flag never exceeds one pending response.

Reset
REQ-030 On rst_n low, immediately: state=BOOT, pc=RESET_PC, drop=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_npc=0; imem_req_addr=RESET_PC.
REQ-031 Reset mid-transaction SHALL abandon any outstanding request; a response arriving after reset release before the first REQ is ignored per REQ-019.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the fetch state enum, INSN_BYTES=4, and the default RESET_PC constant.
REQ-033 Single module; no sub-module required (pc incrementer is inline).

Verification
REQ-034 Reset release, imem ready/rsp next cycle, inst_ready=1 -> requests at 0x0,0x4,0x8,0xC; inst_npc 0x4,0x8,0xC,0x10.
REQ-035 inst_ready=0 for 5 cycles in HOLD -> inst_data/inst_npc stable, no new imem request, then one handshake resumes at next address.
REQ-036 Redirect to 0x0000_0103 while in WAIT -> response for old pc dropped, next request addr 0x0000_0100, inst_npc 0x104.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first inst_npc 0x0000_0000, second request addr 0x0000_0000.
REQ-038 Redirect in HOLD same cycle as inst_ready -> instruction consumed once, next request at target, no duplicate.
REQ-039 rst_n pulsed low during WAIT -> outputs reset asynchronously, late imem_rsp_valid ignored, fetch restarts at RESET_PC.
